imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction-memory depth in 32-bit words; legal word count per image 1..DEPTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse requesting a new image load.
REQ-005 byte_in  input  8  incoming image byte.
REQ-006 byte_valid  input  1  byte_in valid this cycle.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle; transfer occurs when byte_valid and byte_ready are both high.
REQ-008 wr_en  output  1  one-cycle write strobe to the instruction-memory write port.
REQ-009 wr_addr  output  32  byte address of the written word; always word-aligned, bits [1:0] = 0.
REQ-010 wr_data  output  32  instruction word to write.
REQ-011 busy  output  1  high in LEN, DATA, WRITE and CSUM.
REQ-012 done  output  1  high while in DONE.
REQ-013 err  output  1  high while in ERR.
REQ-014 cpu_rst_n  output  1  processor reset, active-low; high only in DONE.

Function
REQ-015 FSM states IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR; a start pulse in IDLE, DONE or ERR moves to LEN and clears the word index, byte index and checksum accumulator.
REQ-016 start in LEN, DATA, WRITE or CSUM is ignored.
REQ-017 byte_ready = 1 in LEN, DATA and CSUM, 0 otherwise; byte_ready is a function of state only, never of byte_valid.
REQ-018 LEN: the accepted byte is the word count N; N = 0 or N > DEPTH -> ERR; otherwise store N and go to DATA.
REQ-019 DATA: bytes assemble little-endian (first byte -> wr_data[7:0], fourth byte -> wr_data[31:24]); acceptance of the fourth byte -> WRITE on the next edge.
REQ-020 WRITE: lasts exactly one cycle, byte_ready = 0, wr_en = 1, wr_addr = word_index * 4, wr_data = the assembled word.
REQ-021 Leaving WRITE: the word index increments; if the new index equals N -> CSUM (macro defined) or DONE (macro undefined); otherwise -> DATA.
REQ-022 Cycles with byte_valid low stall the FSM in place with no state change; no internal timeout exists.
REQ-023 wr_en = 0 in every state except WRITE; wr_addr and wr_data hold their last values outside WRITE.
REQ-024 Fewest cycles per word: 4 accept cycles plus 1 WRITE cycle.
REQ-025 DONE and ERR hold until start or reset.

Reset
REQ-026 rst_n low asynchronously forces IDLE; busy = 0, done = 0, err = 0, wr_en = 0, byte_ready = 0, cpu_rst_n = 0, wr_addr = 0, wr_data = 0, all counters and the accumulator = 0.
REQ-027 Reset during a load aborts it with no further wr_en; words already written remain in memory; after reset release the FSM waits in IDLE for start.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: an 8-bit accumulator adds every DATA byte modulo 256; CSUM accepts one byte; (accumulator + byte) mod 256 = 0 -> DONE, otherwise -> ERR.
REQ-029 Macro undefined: no CSUM state and no accumulator; ERR is reachable only through REQ-018.

Verification
REQ-030 start; bytes 01, 13,00,00,00 (macro off) -> one wr_en with wr_addr 0x0, wr_data 0x00000013; then done = 1 and cpu_rst_n = 1.
REQ-031 N = 2; words 0x00500093, 0x00108113 sent with byte_valid toggling every other cycle -> writes to addresses 0x0 and 0x4 with those values, no extra or dropped writes.
REQ-032 Length byte 00, then in a separate run 41 (DEPTH = 64) -> err = 1, no wr_en, cpu_rst_n = 0; a later start plus a valid image -> done = 1.
REQ-033 Macro on; N = 1; word 0x00000013, checksum byte ED -> done = 1; the same run with checksum byte EE -> err = 1.
REQ-034 rst_n asserted after the 6th data byte of an N = 3 load -> only address 0x0 written; all outputs at reset values immediately, before the next clk edge; a new start reloads from address 0x0.
REQ-035 start pulsed during DATA -> ignored; the load completes unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory
// and releases the CPU reset. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst_n
);

    localparam int AW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_n;
    logic [AW-1:0] r_widx;
    logic [1:0]    r_bidx;
    logic [23:0]   r_word;
    logic          r_byte_ready;
    logic          r_wr_en;
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_cpu_rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
    logic [7:0]    w_csum_sum;
`endif

    state_t        w_nxt;
    logic          w_acc;
    logic          w_len_bad;
    logic [AW-1:0] w_widx_inc;
    logic [31:0]   w_addr;
    logic          w_busy_n;
    logic          w_ready_n;

    // ready is a registered decode of state, so acceptance needs only valid
    assign w_acc      = byte_valid & r_byte_ready;
    assign w_len_bad  = (byte_in == 8'd0) || (32'(byte_in) > 32'(DEPTH));
    assign w_widx_inc = r_widx + AW'(1);
    assign w_addr     = 32'(r_widx) << 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_csum_sum = r_csum + byte_in;
`endif

    // next-state decode and the output levels that go with it
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_acc) w_nxt = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_acc && r_bidx == 2'd3) w_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (w_widx_inc == r_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_nxt = S_CSUM;
`else
                    w_nxt = S_DONE;
`endif
                end else begin
                    w_nxt = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_acc) w_nxt = (w_csum_sum == 8'd0) ? S_DONE : S_ERR;
            end
`endif
            default: w_nxt = S_IDLE;
        endcase
        w_busy_n  = (w_nxt == S_LEN) || (w_nxt == S_DATA) ||
                    (w_nxt == S_WRITE);
        w_ready_n = (w_nxt == S_LEN) || (w_nxt == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_busy_n  = w_busy_n  || (w_nxt == S_CSUM);
        w_ready_n = w_ready_n || (w_nxt == S_CSUM);
`endif
    end

    // state, counters, word assembly and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_widx       <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_nxt;
            r_byte_ready <= w_ready_n;
            r_busy       <= w_busy_n;
            r_wr_en      <= (w_nxt == S_WRITE);
            r_done       <= (w_nxt == S_DONE);
            r_err        <= (w_nxt == S_ERR);
            r_cpu_rst_n  <= (w_nxt == S_DONE);
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_widx <= '0;
                        r_bidx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_acc && !w_len_bad) r_n <= AW'(byte_in);
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_bidx <= r_bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= w_csum_sum;
`endif
                        case (r_bidx)
                            2'd0: r_word[7:0]   <= byte_in;
                            2'd1: r_word[15:8]  <= byte_in;
                            2'd2: r_word[23:16] <= byte_in;
                            default: begin
                                r_wr_data <= {byte_in, r_word};
                                r_wr_addr <= w_addr;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_widx <= w_widx_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cpu_rst_n  = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed image loads with hand-computed expectations.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the checksum.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sum = 8'd0;
    int          wn = 0;
    int          base = 0;
    logic [31:0] wa [0:255];
    logic [31:0] wd [0:255];

    imem_loader #(.DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    // log every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (wr_en && wn < 256) begin
            wa[wn] = wr_addr;
            wd[wn] = wr_data;
            wn = wn + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    task automatic pulse_start(input bit clr);
        @(negedge clk);
        start = 1'b1;
        if (clr) sum = 8'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", 32'(byte_ready), 32'd1);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0], gap);
            sum = sum + t[7:0];
            t = t >> 8;
        end
    endtask

    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'd0 - sum, 0);
`endif
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!(done || err) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished"}, 32'(done | err), 32'd1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // single word image
        base = wn;
        pulse_start(1'b1);
        check("len_busy", 32'(busy), 32'd1);
        check("len_ready", 32'(byte_ready), 32'd1);
        check("len_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        send_byte(8'h01, 0);
        send_word(32'h0000_0013, 0);
        finish_image();
        wait_end("one");
        check("one_done", 32'(done), 32'd1);
        check("one_err", 32'(err), 32'd0);
        check("one_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("one_busy", 32'(busy), 32'd0);
        check("one_wr_en_idle", 32'(wr_en), 32'd0);
        check("one_wr_data_hold", wr_data, 32'h0000_0013);
        check("one_nwrites", 32'(wn - base), 32'd1);
        check("one_addr", wa[base], 32'h0);
        check("one_data", wd[base], 32'h0000_0013);

        // two words with byte_valid toggling
        base = wn;
        pulse_start(1'b1);
        send_byte(8'h02, 1);
        send_word(32'h0050_0093, 1);
        send_word(32'h0010_8113, 1);
        finish_image();
        wait_end("two");
        check("two_done", 32'(done), 32'd1);
        check("two_nwrites", 32'(wn - base), 32'd2);
        check("two_addr0", wa[base], 32'h0);
        check("two_data0", wd[base], 32'h0050_0093);
        check("two_addr1", wa[base+1], 32'h4);
        check("two_data1", wd[base+1], 32'h0010_8113);
        check("two_wr_addr_hold", wr_addr, 32'h4);

        // zero length
        base = wn;
        pulse_start(1'b1);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        check("len0_err", 32'(err), 32'd1);
        check("len0_done", 32'(done), 32'd0);
        check("len0_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);

        // length one past DEPTH
        pulse_start(1'b1);
        check("len41_busy", 32'(busy), 32'd1);
        send_byte(8'h41, 0);
        repeat (2) @(negedge clk);
        check("len41_err", 32'(err), 32'd1);
        check("len41_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("len_bad_nwrites", 32'(wn - base), 32'd0);

        // full DEPTH image
        base = wn;
        pulse_start(1'b1);
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) send_word(32'hCAFE_0000 | 32'(i), 0);
        finish_image();
        wait_end("full");
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check("full_nwrites", 32'(wn - base), 32'd64);
        check("full_addr0", wa[base], 32'h0);
        check("full_addr63", wa[base+63], 32'hFC);
        check("full_data63", wd[base+63], 32'hCAFE_003F);

        // start during DATA is ignored
        base = wn;
        pulse_start(1'b1);
        send_byte(8'h01, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        pulse_start(1'b0);
        check("mid_start_busy", 32'(busy), 32'd1);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        sum = 8'hEF + 8'hBE + 8'hAD + 8'hDE;
        finish_image();
        wait_end("mid");
        check("mid_done", 32'(done), 32'd1);
        check("mid_nwrites", 32'(wn - base), 32'd1);
        check("mid_addr", wa[base], 32'h0);
        check("mid_data", wd[base], 32'hDEAD_BEEF);

        // reset in the middle of a 3-word load
        base = wn;
        pulse_start(1'b1);
        send_byte(8'h03, 0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        repeat (3) @(negedge clk);
        check("abort_nwrites", 32'(wn - base), 32'd1);
        check("abort_addr", wa[base], 32'h0);
        check("abort_data", wd[base], 32'h1122_3344);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("post_abort");

        base = wn;
        pulse_start(1'b1);
        send_byte(8'h01, 0);
        send_word(32'h0000_0073, 0);
        finish_image();
        wait_end("reload");
        check("reload_done", 32'(done), 32'd1);
        check("reload_nwrites", 32'(wn - base), 32'd1);
        check("reload_addr", wa[base], 32'h0);
        check("reload_data", wd[base], 32'h0000_0073);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // explicit checksum bytes: good then bad
        pulse_start(1'b1);
        send_byte(8'h01, 0);
        send_word(32'h0000_0013, 0);
        send_byte(8'hED, 0);
        wait_end("csum_ok");
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_err", 32'(err), 32'd0);
        pulse_start(1'b1);
        send_byte(8'h01, 0);
        send_word(32'h0000_0013, 0);
        send_byte(8'hEE, 0);
        wait_end("csum_bad");
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
